// File: rtl/vga_scan_gen.sv
// Raster timing generator and fixed-priority sprite compositor for the VGA path.
// Counters drive the sprite blocks; their layer nibbles are composited and registered with the syncs.
module vga_scan_gen #(
   parameter int          H_VIS      = 640,
   parameter int          H_FP       = 24,
   parameter int          H_SYNC     = 40,
   parameter int          H_BP       = 128,
   parameter int          V_VIS      = 480,
   parameter int          V_FP       = 9,
   parameter int          V_SYNC     = 3,
   parameter int          V_BP       = 28,
   parameter logic        SYNC_POL   = 1'b0,
   parameter logic [11:0] LAYER0_RGB = 12'hFFF,
   parameter logic [11:0] LAYER1_RGB = 12'hF00,
   parameter logic [11:0] LAYER2_RGB = 12'h00F,
   parameter logic [11:0] LAYER3_RGB = 12'h0F0,
   parameter logic [11:0] BG_RGB     = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] pixel_row,
   output logic [11:0] pixel_column,
   output logic        video_on,
   input  logic [15:0] layer_pix,
   output logic        frame_tick,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   // All timing compares are done at 32 bits so porch sums can never wrap the counter width.
   localparam logic [31:0] H_VIS_C    = 32'(H_VIS);
   localparam logic [31:0] H_LAST_C   = 32'(H_TOTAL - 1);
   localparam logic [31:0] HS_START_C = 32'(H_VIS + H_FP);
   localparam logic [31:0] HS_END_C   = 32'(H_VIS + H_FP + H_SYNC);
   localparam logic [31:0] V_VIS_C    = 32'(V_VIS);
   localparam logic [31:0] V_LASTVIS_C = 32'(V_VIS - 1);
   localparam logic [31:0] V_LAST_C   = 32'(V_TOTAL - 1);
   localparam logic [31:0] VS_START_C = 32'(V_VIS + V_FP);
   localparam logic [31:0] VS_END_C   = 32'(V_VIS + V_FP + V_SYNC);

   localparam logic [3:0][11:0] LAYER_RGB = {LAYER3_RGB, LAYER2_RGB, LAYER1_RGB, LAYER0_RGB};

   logic [HW-1:0] h_cnt_reg, h_cnt_next;
   logic [VW-1:0] v_cnt_reg, v_cnt_next;
   logic [31:0]   h_ext, v_ext;
   logic          h_wrap, v_wrap;

   logic [3:0]       layer_hit;
   logic [3:0][11:0] layer_rgb;
   logic [11:0]      rgb_next, rgb_reg;
   logic             hsync_next, hsync_reg;
   logic             vsync_next, vsync_reg;
   logic             frame_tick_next, frame_tick_reg;

   assign h_ext  = 32'(h_cnt_reg);
   assign v_ext  = 32'(v_cnt_reg);
   assign h_wrap = (h_ext == H_LAST_C);
   assign v_wrap = (v_ext == V_LAST_C);

   always_comb begin
      h_cnt_next = h_cnt_reg + 1'b1;
      v_cnt_next = v_cnt_reg;
      if (h_wrap) begin
         h_cnt_next = '0;
         v_cnt_next = v_wrap ? '0 : v_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   assign pixel_column = 12'(h_cnt_reg);
   assign pixel_row    = 12'(v_cnt_reg);
   assign video_on     = (h_ext < H_VIS_C) && (v_ext < V_VIS_C);

   // Each layer's colour is gated per channel by its own 4-bit intensity nibble.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_layer
         logic [3:0] nib;
         assign nib           = layer_pix[gi*4 +: 4];
         assign layer_hit[gi] = |nib;
         assign layer_rgb[gi] = LAYER_RGB[gi] & {nib, nib, nib};
      end
   endgenerate

   // Walk from lowest to highest priority so the lowest-index hit wins.
   always_comb begin
      rgb_next = BG_RGB;
      for (int k = 3; k >= 0; k--) begin
         if (layer_hit[k]) begin
            rgb_next = layer_rgb[k];
         end
      end
      if (!video_on) begin
         rgb_next = '0;
      end
   end

   always_comb begin
      hsync_next      = ((h_ext >= HS_START_C) && (h_ext < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
      vsync_next      = ((v_ext >= VS_START_C) && (v_ext < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
      frame_tick_next = h_wrap && (v_ext == V_LASTVIS_C);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_reg        <= '0;
         hsync_reg      <= ~SYNC_POL;
         vsync_reg      <= ~SYNC_POL;
         frame_tick_reg <= 1'b0;
      end else begin
         rgb_reg        <= rgb_next;
         hsync_reg      <= hsync_next;
         vsync_reg      <= vsync_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   assign vga_r      = rgb_reg[11:8];
   assign vga_g      = rgb_reg[7:4];
   assign vga_b      = rgb_reg[3:0];
   assign vga_hsync  = hsync_reg;
   assign vga_vsync  = vsync_reg;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen using a shrunken raster so several whole frames fit in a short run.
// A position/colour reference model checks every cycle; a vector table and hand sequences cover corners.
module tb_vga_scan_gen;

   localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 10;
   localparam int V_VIS = 30, V_FP = 3, V_SYNC = 2, V_BP = 5;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 60
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 40
   localparam int FRAME   = H_TOTAL * V_TOTAL;             // 2400
   localparam logic        SP  = 1'b0;
   localparam logic [11:0] L0 = 12'hFFF, L1 = 12'hF80, L2 = 12'h0AF, L3 = 12'h0F0, BG = 12'h123;

   logic        clk, rst;
   logic [11:0] pixel_row, pixel_column;
   logic        video_on, frame_tick, vga_hsync, vga_vsync;
   logic [15:0] layer_pix;
   logic [3:0]  vga_r, vga_g, vga_b;

   vga_scan_gen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SP), .LAYER0_RGB(L0), .LAYER1_RGB(L1), .LAYER2_RGB(L2),
      .LAYER3_RGB(L3), .BG_RGB(BG)
   ) dut (
      .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
      .video_on(video_on), .layer_pix(layer_pix), .frame_tick(frame_tick),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          row;
      int          col;
      logic [15:0] lp;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } vec_t;
   vec_t vecs [20];

   int          errors, checks, ref_n;
   int          hs_low, vs_low, ft_cnt, last_ft_n;
   logic [11:0] exp_rgb_q;
   logic        exp_hs_q, exp_vs_q, exp_ft_q;

   function automatic int cur_col();
      return ref_n % H_TOTAL;
   endfunction

   function automatic int cur_row();
      return (ref_n / H_TOTAL) % V_TOTAL;
   endfunction

   function automatic logic [11:0] colour_of(input int k);
      case (k)
         0:       return L0;
         1:       return L1;
         2:       return L2;
         default: return L3;
      endcase
   endfunction

   // Colour the screen shows for a pixel position and set of layer nibbles.
   function automatic logic [11:0] ref_rgb(input int row, input int col, input logic [15:0] lp);
      logic [3:0] nib;
      if (!(col < H_VIS && row < V_VIS)) return 12'h000;
      for (int k = 0; k < 4; k++) begin
         nib = lp[k*4 +: 4];
         if (nib != 4'h0) return colour_of(k) & {nib, nib, nib};
      end
      return BG;
   endfunction

   function automatic logic [15:0] rand_lp();
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 1) v[k*4 +: 4] = 4'($urandom_range(1, 15));
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s n=%0d got=%h want=%h", name, ref_n, got, want);
      end
   endtask

   task automatic clear_model();
      ref_n     = 0;
      exp_rgb_q = 12'h000;
      exp_hs_q  = ~SP;
      exp_vs_q  = ~SP;
      exp_ft_q  = 1'b0;
      last_ft_n = -1;
   endtask

   // Called at a falling edge: check the whole output bundle, drive this cycle's layers, advance.
   task automatic step(input logic [15:0] lp);
      int row, col;
      row = cur_row();
      col = cur_col();
      check("stream",
            64'({pixel_row, pixel_column, video_on, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick}),
            64'({12'(row), 12'(col), (col < H_VIS && row < V_VIS), exp_rgb_q, exp_hs_q, exp_vs_q, exp_ft_q}));
      if (vga_hsync == SP) hs_low++;
      if (vga_vsync == SP) vs_low++;
      if (frame_tick) begin
         ft_cnt++;
         if (last_ft_n >= 0) check("tick_period", 64'(ref_n - last_ft_n), 64'(FRAME));
         last_ft_n = ref_n;
      end
      layer_pix = lp;
      exp_rgb_q = ref_rgb(row, col, lp);
      exp_hs_q  = (col >= H_VIS + H_FP && col < H_VIS + H_FP + H_SYNC) ? SP : ~SP;
      exp_vs_q  = (row >= V_VIS + V_FP && row < V_VIS + V_FP + V_SYNC) ? SP : ~SP;
      exp_ft_q  = (col == H_TOTAL - 1) && (row == V_VIS - 1);
      @(negedge clk);
      ref_n++;
   endtask

   task automatic go_to(input int r, input int c);
      int budget;
      budget = 0;
      while (!(cur_row() == r && cur_col() == c)) begin
         if (budget > FRAME) begin
            check("goto_timeout", 64'(budget), 64'(0));
            return;
         end
         step(rand_lp());
         budget++;
      end
   endtask

   task automatic check_reset(input string name);
      check(name,
            64'({pixel_row, pixel_column, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick}),
            64'({12'd0, 12'd0, 12'h000, ~SP, ~SP, 1'b0}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog n=%0d", ref_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors = 0; checks = 0; hs_low = 0; vs_low = 0; ft_cnt = 0;
      rst = 1'b0;
      layer_pix = 16'h0000;
      clear_model();

      //          row col  layer_pix  rgb      hs    vs
      vecs[0]  = '{10, 20, 16'h0000, 12'h123, 1'b1, 1'b1};
      vecs[1]  = '{10, 43, 16'h0000, 12'h000, 1'b1, 1'b1};
      vecs[2]  = '{10, 44, 16'hFFFF, 12'h000, 1'b0, 1'b1};
      vecs[3]  = '{10, 49, 16'h0000, 12'h000, 1'b0, 1'b1};
      vecs[4]  = '{10, 50, 16'h0000, 12'h000, 1'b1, 1'b1};
      vecs[5]  = '{11,  0, 16'h00F3, 12'h333, 1'b1, 1'b1};
      vecs[6]  = '{11,  1, 16'h00F0, 12'hF80, 1'b1, 1'b1};
      vecs[7]  = '{11,  2, 16'h0A00, 12'h0AA, 1'b1, 1'b1};
      vecs[8]  = '{11,  3, 16'h5000, 12'h050, 1'b1, 1'b1};
      vecs[9]  = '{11,  4, 16'hF001, 12'h111, 1'b1, 1'b1};
      vecs[10] = '{11,  5, 16'h0080, 12'h880, 1'b1, 1'b1};
      vecs[11] = '{12, 39, 16'hF000, 12'h0F0, 1'b1, 1'b1};
      vecs[12] = '{12, 40, 16'h0001, 12'h000, 1'b1, 1'b1};
      vecs[13] = '{29,  0, 16'h0070, 12'h700, 1'b1, 1'b1};
      vecs[14] = '{29, 59, 16'hFFFF, 12'h000, 1'b1, 1'b1};
      vecs[15] = '{30,  0, 16'hFFFF, 12'h000, 1'b1, 1'b1};
      vecs[16] = '{32, 59, 16'h0000, 12'h000, 1'b1, 1'b1};
      vecs[17] = '{33,  0, 16'h0001, 12'h000, 1'b1, 1'b0};
      vecs[18] = '{34, 46, 16'h0000, 12'h000, 1'b0, 1'b0};
      vecs[19] = '{35,  0, 16'h0000, 12'h000, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check_reset("por_state");
      rst = 1'b1;
      clear_model();
      step(rand_lp());
      check("release_advance", 64'({pixel_row, pixel_column}), 64'({12'd0, 12'd1}));

      for (int i = 0; i < 20; i++) begin
         go_to(vecs[i].row, vecs[i].col);
         step(vecs[i].lp);
         check($sformatf("vec%0d", i), 64'({vga_r, vga_g, vga_b, vga_hsync, vga_vsync}),
               64'({vecs[i].rgb, vecs[i].hs, vecs[i].vs}));
      end

      go_to(V_VIS - 1, H_TOTAL - 1);
      step(rand_lp());
      check("vis_end", 64'({pixel_row, pixel_column, video_on, frame_tick}),
            64'({12'(V_VIS), 12'd0, 1'b0, 1'b1}));
      go_to(V_TOTAL - 1, H_TOTAL - 1);
      step(rand_lp());
      check("frame_wrap", 64'({pixel_row, pixel_column, video_on}), 64'({12'd0, 12'd0, 1'b1}));

      hs_low = 0;
      vs_low = 0;
      repeat (2 * FRAME) step(rand_lp());
      check("hsync_low_2f", 64'(hs_low), 64'(2 * V_TOTAL * H_SYNC));
      check("vsync_low_2f", 64'(vs_low), 64'(2 * V_SYNC * H_TOTAL));

      ft_cnt = 0;
      repeat (3 * FRAME) step(rand_lp());
      check("ticks_3f", 64'(ft_cnt), 64'(3));

      go_to(20, 30);
      #2 rst = 1'b0;
      #1 check_reset("async_reset");
      repeat (5) @(posedge clk);
      #1 check_reset("reset_held");
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      step(rand_lp());
      check("restart_pos", 64'({pixel_row, pixel_column}), 64'({12'd0, 12'd1}));
      repeat (2 * H_TOTAL) step(rand_lp());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
